// File: rtl/datapath_exec.sv
// Execution datapath: 8-entry register bank, ALU, and a step sequencer that walks c through 0..NSTEPS-1 once per start.
// Write-back occurs at the clock edge. DONE and done_pulse are decoded from the state register. rd_data is combinational.
module datapath_exec #(
  parameter int W      = 16,
  parameter int NSTEPS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         load_en,
  input  logic [2:0]   load_addr,
  input  logic [W-1:0] load_data,
  input  logic [2:0]   src1,
  input  logic [2:0]   src2,
  input  logic [2:0]   dest,
  input  logic [3:0]   opcode,
  input  logic         WR,
  output logic [2:0]   c,
  output logic         DONE,
  output logic         done_pulse,
  output logic         zero,
  output logic         carry,
  input  logic [2:0]   rd_addr,
  output logic [W-1:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [2:0] LAST = 3'(NSTEPS - 1);
  localparam logic [W:0] ONE  = (W+1)'(1);

  state_t       state_q, state_d;
  logic [2:0]   c_q, c_d;
  logic [W-1:0] regs_q [8];
  logic         zero_q, carry_q;

  logic [W-1:0] a, b, res;
  logic [W:0]   wide;
  logic [3:0]   sh;
  logic         res_cy, res_vld, commit;

  // ALU. Wide intermediates carry the carry, borrow, or shifted-out bit in their extra position.
  always_comb begin
    a       = regs_q[src1];
    b       = regs_q[src2];
    sh      = b[3:0];
    wide    = '0;
    res     = '0;
    res_cy  = 1'b0;
    res_vld = 1'b1;
    case (opcode)
      4'b0000: begin wide = {1'b0, a} + {1'b0, b}; res = wide[W-1:0]; res_cy = wide[W]; end
      4'b0001: begin wide = {1'b0, a} - {1'b0, b}; res = wide[W-1:0]; res_cy = wide[W]; end
      4'b0010: res = a & b;
      4'b0011: res = a | b;
      4'b0100: res = a ^ b;
      4'b0101: res = ~a;
      4'b0110: begin wide = {1'b0, a} + ONE; res = wide[W-1:0]; res_cy = wide[W]; end
      4'b0111: begin wide = {1'b0, a} - ONE; res = wide[W-1:0]; res_cy = wide[W]; end
      4'b1000: res = a;
      4'b1001: res = {{(W-1){1'b0}}, (a < b)};
      4'b1010: begin wide = {1'b0, a} << sh; res = wide[W-1:0]; res_cy = wide[W]; end
      4'b1011: begin wide = {a, 1'b0} >> sh; res = wide[W:1];   res_cy = wide[0]; end
      default: res_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        c_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        commit = WR & res_vld;
        if (c_q == LAST) begin
          state_d = S_FIN;
          c_d     = '0;
        end else begin
          c_d = c_q + 3'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        c_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        c_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      // A preload is accepted only in IDLE. A write-back occurs only in RUN, so the two never collide.
      if (state_q == S_IDLE && load_en) regs_q[load_addr] <= load_data;
      if (commit) begin
        regs_q[dest] <= res;
        zero_q       <= (res == '0);
        carry_q      <= res_cy;
      end
    end
  end

  assign c          = c_q;
  assign DONE       = (state_q != S_RUN);
  assign done_pulse = (state_q == S_FIN);
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign rd_data    = regs_q[rd_addr];

endmodule
